// File: rtl/speech_pkg.sv
// Shared types for the speech recognizer SPI frame controller.
// Holds the frame FSM state enum and the byte/result widths.
package speech_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECEIVE = 3'd1,
        PROCESS = 3'd2,
        READY   = 3'd3,
        SEND    = 3'd4
    } fstate_t;

    localparam int BYTE_W   = 8;
    localparam int RESULT_W = 4;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and finds edges.
// Ports: clk, reset, sck/ss/sdi pins in; registered sck/ss edge
// pulses, synchronized ss level (ss_s) and data (sdi_s) out.
module spi_pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic sdi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_rise,
    output logic ss_fall,
    output logic ss_s,
    output logic sdi_s
);

    logic [1:0] sck_m;
    logic [1:0] ss_m;
    logic [1:0] sdi_m;
    logic       sck_q;
    logic       ss_q;

    // Edge pulses are registered, so pin-to-pulse is three clk edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_m    <= '0;
            ss_m     <= '0;
            sdi_m    <= '0;
            sck_q    <= 1'b0;
            ss_q     <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            ss_rise  <= 1'b0;
            ss_fall  <= 1'b0;
        end else begin
            sck_m    <= {sck_m[0], sck};
            ss_m     <= {ss_m[0], ss};
            sdi_m    <= {sdi_m[0], sdi};
            sck_q    <= sck_m[1];
            ss_q     <= ss_m[1];
            sck_rise <= sck_m[1] & ~sck_q;
            sck_fall <= ~sck_m[1] & sck_q;
            ss_rise  <= ss_m[1] & ~ss_q;
            ss_fall  <= ~ss_m[1] & ss_q;
        end
    end

    assign ss_s  = ss_m[1];
    assign sdi_s = sdi_m[1];

endmodule

// File: rtl/speech_frame_ctrl.sv
// SPI frame controller: captures NSAMPLES bytes into the sample buffer,
// starts the comparison engine and returns its result in a read frame.
// Ports: clk, reset; SPI pins sck/ss/sdi/sdo; buffer write port
// buf_we/buf_addr/buf_wdata; engine start/done/result; busy, err, led.
module speech_frame_ctrl
    import speech_pkg::*;
#(
    parameter int NSAMPLES = 2000,
    parameter int ADDRW    = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                ss,
    input  logic                sdi,
    output logic                sdo,
    output logic                buf_we,
    output logic [ADDRW-1:0]    buf_addr,
    output logic [BYTE_W-1:0]   buf_wdata,
    output logic                start,
    input  logic                done,
    input  logic [RESULT_W-1:0] result,
    output logic                busy,
    output logic                err,
    output logic [BYTE_W-1:0]   led
);

    localparam logic [ADDRW-1:0] LAST = ADDRW'(NSAMPLES - 1);
    localparam int PAD_W = BYTE_W - RESULT_W;

    fstate_t state;
    fstate_t state_n;

    logic sck_rise;
    logic sck_fall;
    logic ss_rise;
    logic ss_fall;
    logic ss_s;
    logic sdi_s;

    logic [BYTE_W-1:0]   shreg;
    logic [BYTE_W-1:0]   tx_byte;
    logic [BYTE_W-1:0]   byte_in;
    logic [2:0]          bitcnt;
    logic [ADDRW-1:0]    waddr;
    logic [RESULT_W-1:0] res_q;
    logic                last_wr;

    spi_pin_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .ss       (ss),
        .sdi      (sdi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_rise  (ss_rise),
        .ss_fall  (ss_fall),
        .ss_s     (ss_s),
        .sdi_s    (sdi_s)
    );

    assign byte_in = {shreg[BYTE_W-2:0], sdi_s};
    // The final byte's write strobe is what ends the capture frame.
    assign last_wr = buf_we && (buf_addr == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (ss_rise) state_n = RECEIVE;
            RECEIVE: begin
                if (last_wr)      state_n = PROCESS;
                else if (ss_fall) state_n = IDLE;
            end
            PROCESS: if (done)    state_n = READY;
            READY:   if (ss_rise) state_n = SEND;
            SEND:    if (ss_fall) state_n = IDLE;
            default:              state_n = IDLE;
        endcase
    end

    always_comb begin
        sdo  = 1'b0;
        busy = 1'b0;
        unique case (state)
            RECEIVE: busy = 1'b1;
            PROCESS: busy = 1'b1;
            SEND:    sdo  = tx_byte[BYTE_W-1];
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_we    <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            start     <= 1'b0;
            err       <= 1'b0;
            led       <= '0;
            shreg     <= '0;
            tx_byte   <= '0;
            bitcnt    <= '0;
            waddr     <= '0;
            res_q     <= '0;
        end else begin
            buf_we <= 1'b0;
            start  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ss_rise) begin
                        err    <= 1'b0;
                        waddr  <= '0;
                        bitcnt <= '0;
                    end
                end
                RECEIVE: begin
                    if (last_wr) begin
                        start <= 1'b1;
                    end else if (ss_fall) begin
                        err <= 1'b1;
                    end else if (sck_rise && ss_s) begin
                        shreg  <= byte_in;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            buf_we    <= 1'b1;
                            buf_addr  <= waddr;
                            buf_wdata <= byte_in;
                            led       <= byte_in;
                            waddr     <= waddr + ADDRW'(1);
                        end
                    end
                end
                PROCESS: begin
                    if (done) begin
                        tx_byte <= {{PAD_W{1'b0}}, result};
                        res_q   <= result;
                    end
                end
                READY: begin
                    if (ss_rise) bitcnt <= '0;
                end
                SEND: begin
                    if (sck_fall && ss_s) begin
                        bitcnt <= bitcnt + 3'd1;
                        // Reload after each byte so the master can
                        // keep reading the same result.
                        if (bitcnt == 3'd7)
                            tx_byte <= {{PAD_W{1'b0}}, res_q};
                        else
                            tx_byte <= {tx_byte[BYTE_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_speech_frame_ctrl.sv
// Scoreboard bench for speech_frame_ctrl with NSAMPLES=4.
// Stimulus queues expected events; a monitor compares DUT outputs.
module tb_speech_frame_ctrl;
    import speech_pkg::*;

    localparam int NS = 4;
    localparam int AW = 2;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          sck    = 1'b0;
    logic          ss     = 1'b0;
    logic          sdi    = 1'b0;
    logic          done   = 1'b0;
    logic [3:0]    result = 4'h0;
    logic          sdo;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_wdata;
    logic          start;
    logic          busy;
    logic          err;
    logic [7:0]    led;

    always #5 clk = ~clk;

    speech_frame_ctrl #(.NSAMPLES(NS), .ADDRW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .ss        (ss),
        .sdi       (sdi),
        .sdo       (sdo),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .start     (start),
        .done      (done),
        .result    (result),
        .busy      (busy),
        .err       (err),
        .led       (led)
    );

    typedef struct {int kind; int a; int d;} ev_t;
    typedef struct {int id; int val;} pr_t;

    ev_t exp_ev[$];
    int  exp_rx[$];
    int  obs_rx[$];
    pr_t exp_pr[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit fin = 1'b0;
    bit chk_done = 1'b0;
    bit rd_mode = 1'b0;

    localparam int P_SDO = 0, P_WE = 1, P_ADDR = 2, P_WDATA = 3;
    localparam int P_START = 4, P_BUSY = 5, P_ERR = 6, P_LED = 7;
    localparam int P_STATE = 8, P_TX = 9;

    function automatic int probe_val(input int id);
        case (id)
            P_SDO:   return int'(sdo);
            P_WE:    return int'(buf_we);
            P_ADDR:  return int'(buf_addr);
            P_WDATA: return int'(buf_wdata);
            P_START: return int'(start);
            P_BUSY:  return int'(busy);
            P_ERR:   return int'(err);
            P_LED:   return int'(led);
            P_STATE: return int'(dut.state);
            default: return int'(dut.tx_byte);
        endcase
    endfunction

    function automatic string pname(input int id);
        case (id)
            P_SDO:   return "sdo";
            P_WE:    return "buf_we";
            P_ADDR:  return "buf_addr";
            P_WDATA: return "buf_wdata";
            P_START: return "start";
            P_BUSY:  return "busy";
            P_ERR:   return "err";
            P_LED:   return "led";
            P_STATE: return "state";
            default: return "tx_byte";
        endcase
    endfunction

    // Master-side receiver: samples sdo on rising sck in read frames.
    logic [7:0] rx_sh = 8'h00;
    int         rx_n  = 0;
    always begin
        @(posedge sck or negedge ss);
        if (!ss) begin
            rx_n = 0;
        end else if (rd_mode) begin
            rx_sh = {rx_sh[6:0], sdo};
            rx_n++;
            if (rx_n == 8) begin
                obs_rx.push_back(int'(rx_sh));
                rx_n = 0;
            end
        end
    end

    always @(negedge clk) begin : mon
        ev_t e;
        pr_t p;
        int  o;
        int  x;
        if (buf_we) begin
            n_cmp++;
            if (exp_ev.size() == 0) begin
                n_bad++;
                $display("FAIL write: unexpected addr=%0d data=%02h",
                         buf_addr, buf_wdata);
            end else begin
                e = exp_ev.pop_front();
                if (e.kind != 0 || e.a != int'(buf_addr) ||
                    e.d != int'(buf_wdata)) begin
                    n_bad++;
                    $display("FAIL write: got addr=%0d data=%02h, want kind=%0d addr=%0d data=%02h",
                             buf_addr, buf_wdata, e.kind, e.a, e.d);
                end
            end
        end
        if (start) begin
            n_cmp++;
            if (exp_ev.size() == 0) begin
                n_bad++;
                $display("FAIL start: unexpected pulse at %0t", $time);
            end else begin
                e = exp_ev.pop_front();
                if (e.kind != 1) begin
                    n_bad++;
                    $display("FAIL start: got start, want write addr=%0d data=%02h",
                             e.a, e.d);
                end
            end
        end
        while (obs_rx.size() > 0) begin
            o = obs_rx.pop_front();
            n_cmp++;
            if (exp_rx.size() == 0) begin
                n_bad++;
                $display("FAIL read: unexpected byte %02h", o);
            end else begin
                x = exp_rx.pop_front();
                if (o != x) begin
                    n_bad++;
                    $display("FAIL read: got %02h want %02h", o, x);
                end
            end
        end
        while (exp_pr.size() > 0) begin
            p = exp_pr.pop_front();
            n_cmp++;
            if (probe_val(p.id) != p.val) begin
                n_bad++;
                $display("FAIL %s: got %0h want %0h at %0t",
                         pname(p.id), probe_val(p.id), p.val, $time);
            end
        end
        if (fin && !chk_done) begin
            n_cmp++;
            if (exp_ev.size() != 0 || exp_rx.size() != 0 ||
                obs_rx.size() != 0) begin
                n_bad++;
                $display("FAIL drain: left ev=%0d rx=%0d obs=%0d want 0",
                         exp_ev.size(), exp_rx.size(), obs_rx.size());
            end
            chk_done = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits = 8);
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = b[i];
            tick(5);
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
        end
    endtask

    task automatic ss_on();
        ss = 1'b1;
        tick(6);
    endtask

    task automatic ss_off();
        tick(3);
        ss = 1'b0;
        tick(6);
    endtask

    task automatic exp_wr(input int a, input int d);
        ev_t e;
        e = '{0, a, d};
        exp_ev.push_back(e);
    endtask

    task automatic exp_st();
        ev_t e;
        e = '{1, 0, 0};
        exp_ev.push_back(e);
    endtask

    task automatic probe(input int id, input int val);
        pr_t p;
        p = '{id, val};
        exp_pr.push_back(p);
    endtask

    task automatic probe_idle_zero();
        probe(P_SDO, 0);
        probe(P_WE, 0);
        probe(P_ADDR, 0);
        probe(P_WDATA, 0);
        probe(P_START, 0);
        probe(P_BUSY, 0);
        probe(P_ERR, 0);
        probe(P_LED, 0);
        probe(P_STATE, int'(IDLE));
        tick(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        probe_idle_zero();
        probe(P_TX, 0);
        tick(2);

        result = 4'h3;
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(2);
        probe(P_STATE, int'(IDLE));
        probe(P_TX, 0);
        tick(2);

        exp_wr(0, 8'hC3);
        exp_wr(1, 8'h3C);
        ss_on();
        spi_byte(8'hC3);
        spi_byte(8'h3C);
        tick(2);
        reset = 1'b1;
        ss = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(3);
        probe_idle_zero();

        exp_wr(0, 8'h12);
        exp_wr(1, 8'h34);
        exp_wr(2, 8'h56);
        exp_wr(3, 8'h78);
        exp_st();
        ss_on();
        spi_byte(8'h12);
        spi_byte(8'h34);
        spi_byte(8'h56);
        spi_byte(8'h78);
        tick(3);
        probe(P_LED, 8'h78);
        probe(P_BUSY, 1);
        probe(P_STATE, int'(PROCESS));
        probe(P_SDO, 0);
        probe(P_ERR, 0);
        tick(2);
        spi_byte(8'h9A);
        ss_off();
        probe(P_STATE, int'(PROCESS));
        probe(P_LED, 8'h78);
        tick(2);

        result = 4'hA;
        done = 1'b1;
        tick(1);
        done = 1'b0;
        result = 4'h5;
        tick(2);
        probe(P_STATE, int'(READY));
        probe(P_TX, 8'h0A);
        probe(P_BUSY, 0);
        tick(2);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(2);
        probe(P_STATE, int'(READY));
        probe(P_TX, 8'h0A);
        tick(2);

        rd_mode = 1'b1;
        exp_rx.push_back(8'h0A);
        exp_rx.push_back(8'h0A);
        ss_on();
        probe(P_STATE, int'(SEND));
        tick(2);
        spi_byte(8'h00);
        spi_byte(8'h00);
        ss_off();
        rd_mode = 1'b0;
        probe(P_SDO, 0);
        probe(P_STATE, int'(IDLE));
        tick(2);

        exp_wr(0, 8'h11);
        exp_wr(1, 8'h22);
        ss_on();
        spi_byte(8'h11);
        spi_byte(8'h22);
        spi_byte(8'hE0, 3);
        ss_off();
        probe(P_ERR, 1);
        probe(P_STATE, int'(IDLE));
        probe(P_LED, 8'h22);
        probe(P_BUSY, 0);
        tick(2);
        ss_on();
        probe(P_ERR, 0);
        probe(P_STATE, int'(RECEIVE));
        probe(P_BUSY, 1);
        tick(2);
        ss_off();
        probe(P_ERR, 1);
        probe(P_STATE, int'(IDLE));
        tick(2);

        for (int i = 0; i < 16; i++) begin
            tick(3);
            sck = ~sck;
        end
        sck = 1'b0;
        tick(4);
        probe(P_SDO, 0);
        probe(P_WE, 0);
        probe(P_STATE, int'(IDLE));
        tick(2);

        fin = 1'b1;
        for (int i = 0; i < 100 && !chk_done; i++) tick(1);
        if (!chk_done) begin
            $display("FAIL drain: monitor did not finish, got 0 want 1");
            $fatal(1, "drain timeout");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
